// File: rtl/flash_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : flash_arb_pkg
// Brief    : Shared state encoding and requester indices for the flash arbiter
// Revision : 1.0
// ============================================================================
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam logic REQ_LOADER = 1'b0;
  localparam logic REQ_AUX    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Brief    : Combinational two-way round-robin picker
// Revision : 1.0
// ============================================================================
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       gnt,
  output logic       any
);

  // On a tie the requester that was not served last goes next
  always_comb begin
    any = |valid;
    if (valid == 2'b11) begin
      gnt = ~last;
    end else begin
      gnt = valid[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : flash_read_arbiter
// Brief    : Shares one SPI-flash word reader between two requesters
// Revision : 1.0
// ============================================================================
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        req_ready,
  output logic [1:0]        req_err,
  output logic [DATA_W-1:0] req_rdata,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_reset,
  output logic              busy,
  output logic              grant_id
);

  localparam int GAP_W      = $clog2(GAP_CYCLES + 2);
  localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_LOAD_I[GAP_W-1:0];

  arb_state_e          state_q, state_d;
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_reset_q, mem_reset_d;
  logic [1:0]          req_ready_q, req_ready_d;
  logic [1:0]          req_err_q, req_err_d;
  logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;
  logic                grant_q, grant_d;
  logic                prio_q, prio_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [TIMEOUT_W-1:0] wd_inc;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [1:0]          pick_valid;
  logic [1:0]          grant_onehot;
  logic                pick_gnt;
  logic                pick_any;

  // A requester being acknowledged this cycle still shows valid; keep it out
  assign pick_valid = req_valid & ~req_ready_q;

  rr_pick2 u_pick (
    .valid (pick_valid),
    .last  (~prio_q),
    .gnt   (pick_gnt),
    .any   (pick_any)
  );

  assign grant_onehot = (grant_q == REQ_AUX) ? 2'b10 : 2'b01;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_reset_d = 1'b0;
    req_ready_d = 2'b00;
    req_err_d   = 2'b00;
    req_rdata_d = req_rdata_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    wd_inc      = wd_q + TIMEOUT_W'(1);
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = BUSY;
          mem_valid_d = 1'b1;
          mem_addr_d  = (pick_gnt == REQ_AUX) ? req_addr1 : req_addr0;
          grant_d     = pick_gnt;
          wd_d        = '0;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          req_ready_d = grant_onehot;
          req_rdata_d = mem_rdata;
          prio_d      = ~grant_q;
          gap_d       = GAP_LOAD;
          state_d     = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else if (&wd_inc) begin
          // Stalled reader: abort, reset it and always leave at least one recovery cycle
          mem_valid_d = 1'b0;
          mem_reset_d = 1'b1;
          req_ready_d = grant_onehot;
          req_err_d   = grant_onehot;
          req_rdata_d = '0;
          prio_d      = ~grant_q;
          gap_d       = GAP_LOAD;
          state_d     = GAP;
        end else begin
          wd_d = wd_inc;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_reset_q <= 1'b0;
      req_ready_q <= 2'b00;
      req_err_q   <= 2'b00;
      req_rdata_q <= '0;
      grant_q     <= 1'b0;
      prio_q      <= 1'b0;
      wd_q        <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_reset_q <= mem_reset_d;
      req_ready_q <= req_ready_d;
      req_err_q   <= req_err_d;
      req_rdata_q <= req_rdata_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
    end
  end

  assign req_ready = req_ready_q;
  assign req_err   = req_err_q;
  assign req_rdata = req_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_reset = mem_reset_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;

endmodule
`default_nettype wire
